// File: rtl/rbm_pkg.sv
// Shared definitions for the vRBM classifier datapath.
// Contents: FSM state codes, saturation limits, linear-sigmoid constants,
// LFSR feedback polynomial and flattened-bus index helpers.
package rbm_pkg;

  // Controller states (plain constants so legacy tools can consume them)
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHid  = 2'd1;
  localparam logic [1:0] StCls  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Pre-activations are clipped to a 12-bit signed range before the sigmoid
  localparam int unsigned SatW = 12;
  localparam logic signed [SatW-1:0] PosInf = 12'sh7FF;
  localparam logic signed [SatW-1:0] NegInf = 12'sh800;

  // Linear sigmoid p = 128 + (s >>> 2), weights in Q3.8
  localparam int SigOffset = 128;
  localparam int unsigned SigShift = 2;

  // Galois right-shift toggle mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  function automatic int unsigned flat1(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  function automatic int unsigned flat2(input int unsigned row, input int unsigned col,
                                        input int unsigned cols, input int unsigned width);
    return (row * cols + col) * width;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/rbm_layer.sv
// One stochastic RBM layer: weighted sum of binary inputs plus bias, saturation,
// linear sigmoid, per-layer LFSR and a registered Bernoulli sample per unit.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   sample_en_i    - take a new sample (and advance the LFSR) on this edge
//   data_i         - binary layer inputs
//   weight_i       - W[i][j] at [(i*out_dim+j)*w +: w]
//   bias_i         - b[j] at [j*w +: w]
//   switch_i       - per-unit enable; disabled units always sample 0
//   sample_o       - registered unit samples
module rbm_layer
  import rbm_pkg::*;
#(
  parameter int unsigned in_dim            = 784,
  parameter int unsigned out_dim           = 441,
  parameter int unsigned w_bitlength       = 12,
  parameter int unsigned sigmoid_bitlength = 8,
  parameter logic [31:0] seed              = 32'hACE1_0001
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                sample_en_i,
  input  logic [in_dim-1:0]                   data_i,
  input  logic [in_dim*out_dim*w_bitlength-1:0] weight_i,
  input  logic [out_dim*w_bitlength-1:0]      bias_i,
  input  logic [out_dim-1:0]                  switch_i,
  output logic [out_dim-1:0]                  sample_o
);

  // Wide enough that bias plus in_dim weights can never wrap
  localparam int unsigned SumW = w_bitlength + $clog2(in_dim + 1) + 1;
  localparam logic signed [SumW-1:0] SatMax = PosInf;
  localparam logic signed [SumW-1:0] SatMin = NegInf;
  localparam int PMax = (1 << sigmoid_bitlength) - 1;

  function automatic logic signed [SumW-1:0] sext(input logic [w_bitlength-1:0] v);
    return {{(SumW - w_bitlength){v[w_bitlength-1]}}, v};
  endfunction

  logic [31:0]                  lfsr_q, lfsr_d;
  logic [out_dim-1:0]           sample_q, sample_d, sample_next;
  logic signed [SumW-1:0]       sum;
  logic signed [SatW-1:0]       sat;
  int                           pre;
  logic [sigmoid_bitlength-1:0] prob, rnd;
  logic [63:0]                  lfsr_dbl;

  always_comb begin
    sum         = '0;
    sat         = '0;
    pre         = 0;
    prob        = '0;
    rnd         = '0;
    sample_next = '0;
    // Doubled word lets units near bit 31 take a wrap-around window
    lfsr_dbl    = {lfsr_q, lfsr_q};
    for (int j = 0; j < out_dim; j++) begin
      sum = sext(bias_i[flat1(j, w_bitlength) +: w_bitlength]);
      for (int i = 0; i < in_dim; i++) begin
        if (data_i[i]) begin
          sum = sum + sext(weight_i[flat2(i, j, out_dim, w_bitlength) +: w_bitlength]);
        end
      end
      if (sum > SatMax) begin
        sat = PosInf;
      end else if (sum < SatMin) begin
        sat = NegInf;
      end else begin
        sat = sum[SatW-1:0];
      end
      pre = SigOffset + (int'(sat) >>> SigShift);
      if (pre < 0) begin
        prob = '0;
      end else if (pre > PMax) begin
        prob = '1;
      end else begin
        prob = sigmoid_bitlength'(pre);
      end
      rnd = lfsr_dbl[(j % 32) +: sigmoid_bitlength];
      sample_next[j] = switch_i[j] & (rnd < prob);
    end
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    sample_d = sample_q;
    if (sample_en_i) begin
      lfsr_d   = lfsr_step(lfsr_q);
      sample_d = sample_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q   <= seed;
      sample_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/rbm_main.sv
// Stochastic RBM classifier core. Latches one binary image, then runs
// iteration_num hidden/classifier sampling passes, counting per class how many
// passes fired that class unit, and finally raises finish until reset.
// Configuration macro: SPARSE_EN (input_dim defaults to 64 instead of 784; only
// the first input_dim rows of HiddenWeightPort are used).
// Ports:
//   reset            - asynchronous active-low reset
//   clock            - rising-edge clock
//   data_valid       - start request, honoured only in idle
//   HiddenWeightPort - hidden weights, general_input_dim rows x hidden_dim
//   HiddenBiasPort   - hidden biases
//   HiddenSwitchPort - hidden unit enables
//   ClassiWeightPort - classifier weights, hidden_dim rows x output_dim
//   ClassiBiasPort   - classifier biases
//   ClassiSwitchPort - classifier unit enables
//   InputDataPort    - binary image pixels
//   OutputDataPort   - per-class fire counts, class k at [k*w +: w]
//   finish           - counts are final
module rbm_main
  import rbm_pkg::*;
#(
`ifdef SPARSE_EN
  parameter int unsigned input_dim         = 64,
`else
  parameter int unsigned input_dim         = 784,
`endif
  parameter int unsigned general_input_dim = 784,
  parameter int unsigned hidden_dim        = 441,
  parameter int unsigned output_dim        = 10,
  parameter int unsigned w_bitlength       = 12,
  parameter int unsigned sigmoid_bitlength = 8,
  parameter int unsigned iteration_num     = 100,
  parameter logic [31:0] h_seed            = 32'hACE1_0001,
  parameter logic [31:0] c_seed            = 32'h1234_5678
) (
  input  logic                                            reset,
  input  logic                                            clock,
  input  logic                                            data_valid,
  input  logic [general_input_dim*hidden_dim*w_bitlength-1:0] HiddenWeightPort,
  input  logic [hidden_dim*w_bitlength-1:0]               HiddenBiasPort,
  input  logic [hidden_dim-1:0]                           HiddenSwitchPort,
  input  logic [hidden_dim*output_dim*w_bitlength-1:0]    ClassiWeightPort,
  input  logic [output_dim*w_bitlength-1:0]               ClassiBiasPort,
  input  logic [output_dim-1:0]                           ClassiSwitchPort,
  input  logic [input_dim-1:0]                            InputDataPort,
  output logic [output_dim*w_bitlength-1:0]               OutputDataPort,
  output logic                                            finish
);

  localparam int unsigned IterW = $clog2(iteration_num + 1);

  logic [1:0]                                 state_q, state_d;
  logic [IterW-1:0]                           iter_q, iter_d;
  logic [input_dim-1:0]                       x_q, x_d;
  logic [output_dim-1:0][w_bitlength-1:0]     count_q, count_d;
  logic                                       cls_valid_q, cls_valid_d;
  logic                                       finish_q, finish_d;
  logic [hidden_dim-1:0]                      hid_sample;
  logic [output_dim-1:0]                      cls_sample;

  rbm_layer #(
    .in_dim            (input_dim),
    .out_dim           (hidden_dim),
    .w_bitlength       (w_bitlength),
    .sigmoid_bitlength (sigmoid_bitlength),
    .seed              (h_seed)
  ) u_hidden (
    .clk_i       (clock),
    .rst_ni      (reset),
    .sample_en_i (state_q == StHid),
    .data_i      (x_q),
    .weight_i    (HiddenWeightPort[input_dim*hidden_dim*w_bitlength-1:0]),
    .bias_i      (HiddenBiasPort),
    .switch_i    (HiddenSwitchPort),
    .sample_o    (hid_sample)
  );

  rbm_layer #(
    .in_dim            (hidden_dim),
    .out_dim           (output_dim),
    .w_bitlength       (w_bitlength),
    .sigmoid_bitlength (sigmoid_bitlength),
    .seed              (c_seed)
  ) u_classi (
    .clk_i       (clock),
    .rst_ni      (reset),
    .sample_en_i (state_q == StCls),
    .data_i      (hid_sample),
    .weight_i    (ClassiWeightPort),
    .bias_i      (ClassiBiasPort),
    .switch_i    (ClassiSwitchPort),
    .sample_o    (cls_sample)
  );

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    x_d         = x_q;
    count_d     = count_q;
    cls_valid_d = 1'b0;
    finish_d    = (state_q == StDone);
    // Classifier samples are registered, so each pass is counted on the edge
    // after its CLS cycle; the last one lands together with finish.
    if (cls_valid_q) begin
      for (int k = 0; k < output_dim; k++) begin
        count_d[k] = count_q[k] + {{(w_bitlength - 1){1'b0}}, cls_sample[k]};
      end
    end
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          x_d     = InputDataPort;
          iter_d  = '0;
          count_d = '0;
          state_d = StHid;
        end
      end
      StHid: state_d = StCls;
      StCls: begin
        cls_valid_d = 1'b1;
        iter_d      = iter_q + IterW'(1);
        state_d     = (iter_d == IterW'(iteration_num)) ? StDone : StHid;
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      x_q         <= '0;
      count_q     <= '0;
      cls_valid_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      count_q     <= count_d;
      cls_valid_q <= cls_valid_d;
      finish_q    <= finish_d;
    end
  end

  assign OutputDataPort = count_q;
  assign finish         = finish_q;

endmodule

// File: tb/tb_rbm_main.sv
// Self-checking bench for rbm_main with reduced dimensions; input_dim is set
// below general_input_dim so the unused weight rows can be exercised.
module tb_rbm_main;

  localparam int IN = 8, GIN = 12, HD = 6, OD = 10, W = 12, SB = 8, IT = 100;
  localparam logic [31:0] HSEED = 32'hACE1_0001, CSEED = 32'h1234_5678;

  logic clock = 1'b0, reset = 1'b0, data_valid = 1'b0;
  logic [GIN*HD*W-1:0] hw_bus = '0;
  logic [HD*W-1:0]     hb_bus = '0;
  logic [HD-1:0]       hsw_bus = '0;
  logic [HD*OD*W-1:0]  cw_bus = '0;
  logic [OD*W-1:0]     cb_bus = '0;
  logic [OD-1:0]       csw_bus = '0;
  logic [IN-1:0]       x_bus = '0;
  logic [OD*W-1:0]     out_bus;
  logic                finish;

  rbm_main #(
    .input_dim(IN), .general_input_dim(GIN), .hidden_dim(HD), .output_dim(OD),
    .w_bitlength(W), .sigmoid_bitlength(SB), .iteration_num(IT),
    .h_seed(HSEED), .c_seed(CSEED)
  ) dut (
    .reset(reset), .clock(clock), .data_valid(data_valid),
    .HiddenWeightPort(hw_bus), .HiddenBiasPort(hb_bus), .HiddenSwitchPort(hsw_bus),
    .ClassiWeightPort(cw_bus), .ClassiBiasPort(cb_bus), .ClassiSwitchPort(csw_bus),
    .InputDataPort(x_bus), .OutputDataPort(out_bus), .finish(finish)
  );

  always #5 clock = ~clock;

  // Model-side parameters, packed onto the buses before every run
  int hw_m[GIN][HD];
  int hb_m[HD];
  bit hsw_m[HD];
  int cw_m[HD][OD];
  int cb_m[OD];
  bit csw_m[OD];
  bit x_m[IN];
  int exp_cnt[OD];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IN-1:0] x;
    int            hw_lo;   // rows below input_dim
    int            hw_hi;   // rows at or above input_dim
    int            hb;
    int            cw;
    int            cb;
    logic [OD-1:0] csw;
    int            lo;      // expected range for enabled classes
    int            hi;
  } vec_t;

  vec_t  vecs[4];
  string vec_name[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int get_count(input int k);
    return int'(out_bus[k*W +: W]);
  endfunction

  function automatic int nonzero_counts();
    int n = 0;
    for (int k = 0; k < OD; k++) if (get_count(k) != 0) n++;
    return n;
  endfunction

  // ---------------- reference model ----------------
  function automatic int prob(input int s);
    int p;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    p = 128 + (s >>> 2);
    if (p < 0) p = 0;
    if (p > 255) p = 255;
    return p;
  endfunction

  function automatic int rnd(input logic [31:0] l, input int n);
    logic [63:0] d;
    d = {l, l};
    return int'((d >> (n % 32)) & 64'hFF);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic run_model(input int nit);
    logic [31:0] lh, lc;
    bit h[HD];
    int s;
    lh = HSEED;
    lc = CSEED;
    for (int k = 0; k < OD; k++) exp_cnt[k] = 0;
    for (int it = 0; it < nit; it++) begin
      for (int j = 0; j < HD; j++) begin
        s = hb_m[j];
        for (int i = 0; i < IN; i++) if (x_m[i]) s += hw_m[i][j];
        h[j] = hsw_m[j] && (rnd(lh, j) < prob(s));
      end
      lh = step(lh);
      for (int k = 0; k < OD; k++) begin
        s = cb_m[k];
        for (int j = 0; j < HD; j++) if (h[j]) s += cw_m[j][k];
        if (csw_m[k] && (rnd(lc, k) < prob(s))) exp_cnt[k]++;
      end
      lc = step(lc);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pack_buses();
    for (int i = 0; i < GIN; i++)
      for (int j = 0; j < HD; j++) hw_bus[(i*HD+j)*W +: W] = W'(hw_m[i][j]);
    for (int j = 0; j < HD; j++) begin
      hb_bus[j*W +: W] = W'(hb_m[j]);
      hsw_bus[j] = hsw_m[j];
      for (int k = 0; k < OD; k++) cw_bus[(j*OD+k)*W +: W] = W'(cw_m[j][k]);
    end
    for (int k = 0; k < OD; k++) begin
      cb_bus[k*W +: W] = W'(cb_m[k]);
      csw_bus[k] = csw_m[k];
    end
    for (int i = 0; i < IN; i++) x_bus[i] = x_m[i];
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < GIN; i++)
      for (int j = 0; j < HD; j++) hw_m[i][j] = (i < IN) ? v.hw_lo : v.hw_hi;
    for (int j = 0; j < HD; j++) begin
      hb_m[j] = v.hb;
      hsw_m[j] = 1'b1;
      for (int k = 0; k < OD; k++) cw_m[j][k] = v.cw;
    end
    for (int k = 0; k < OD; k++) begin
      cb_m[k] = v.cb;
      csw_m[k] = v.csw[k];
    end
    for (int i = 0; i < IN; i++) x_m[i] = v.x[i];
    pack_buses();
  endtask

  function automatic int srand(input int span);
    return int'($urandom_range(0, 2 * span)) - span;
  endfunction

  task automatic load_random();
    for (int i = 0; i < GIN; i++)
      for (int j = 0; j < HD; j++) hw_m[i][j] = srand(700);
    for (int j = 0; j < HD; j++) begin
      hb_m[j] = srand(600);
      hsw_m[j] = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < OD; k++) cw_m[j][k] = srand(700);
    end
    for (int k = 0; k < OD; k++) begin
      cb_m[k] = srand(600);
      csw_m[k] = ($urandom_range(0, 7) != 0);
    end
    for (int i = 0; i < IN; i++) x_m[i] = $urandom_range(0, 1);
    pack_buses();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic start();
    @(negedge clock);
    data_valid = 1'b1;
    @(negedge clock);          // just after the start edge
    data_valid = 1'b0;
  endtask

  // Starts a run, checks finish latency, exact counts and the hold in DONE
  task automatic run_and_check(input string name, input bit use_rng, input int lo,
                               input int hi);
    int lat;
    start();
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if (finish === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({name, "_finish_latency"}, lat, 2 * IT + 1);
    run_model(IT);
    for (int k = 0; k < OD; k++) begin
      check($sformatf("%s_count%0d", name, k), get_count(k), exp_cnt[k]);
      if (use_rng) begin
        if (csw_m[k]) check_range($sformatf("%s_range%0d", name, k), get_count(k), lo, hi);
        else          check($sformatf("%s_disabled%0d", name, k), get_count(k), 0);
      end
    end
    // data_valid in DONE must not restart or disturb the result
    data_valid = 1'b1;
    repeat (3) @(negedge clock);
    data_valid = 1'b0;
    @(negedge clock);
    check({name, "_finish_held"}, int'(finish), 1);
    for (int k = 0; k < OD; k++)
      check($sformatf("%s_hold%0d", name, k), get_count(k), exp_cnt[k]);
  endtask

  initial begin
    vecs[0] = '{x: 8'hA5, hw_lo: 0, hw_hi: 0, hb: 2047, cw: 0, cb: 2047,
                csw: 10'h3FF, lo: 96, hi: 100};
    vec_name[0] = "all_fire";
    vecs[1] = '{x: 8'hFF, hw_lo: -2048, hw_hi: -2048, hb: -2048, cw: -2048, cb: -2048,
                csw: 10'h3FF, lo: 0, hi: 0};
    vec_name[1] = "all_neg";
    vecs[2] = '{x: 8'h3C, hw_lo: 0, hw_hi: 0, hb: 0, cw: 0, cb: 2047,
                csw: 10'b00_0000_0001, lo: 96, hi: 100};
    vec_name[2] = "one_class";
    // Upper rows would drive hidden sums negative if they leaked in
    vecs[3] = '{x: 8'hFF, hw_lo: 300, hw_hi: -2048, hb: 0, cw: 1024, cb: -2048,
                csw: 10'h3FF, lo: 96, hi: 100};
    vec_name[3] = "sparse_rows";

    // Reset held, then released with no start request
    repeat (3) @(negedge clock);
    check("in_reset_finish", int'(finish), 0);
    check("in_reset_outputs", nonzero_counts(), 0);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (100) @(negedge clock);
      check($sformatf("idle_finish_%0d", r), int'(finish), 0);
      check($sformatf("idle_outputs_%0d", r), nonzero_counts(), 0);
    end

    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      do_reset();
      run_and_check(vec_name[v], 1'b1, vecs[v].lo, vecs[v].hi);
    end

    // Reset 50 cycles into a run, then a fresh start without any other reset
    load_vec(vecs[0]);
    do_reset();
    start();
    repeat (49) @(negedge clock);
    check("midrun_finish_low", int'(finish), 0);
    check_range("midrun_partial_count0", get_count(0), 20, 25);
    reset = 1'b0;
    #1;
    check("midrun_reset_finish", int'(finish), 0);
    check("midrun_reset_outputs", nonzero_counts(), 0);
    @(negedge clock);
    reset = 1'b1;
    run_and_check("after_abort", 1'b1, 96, 100);

    for (int r = 0; r < 3; r++) begin
      load_random();
      do_reset();
      run_and_check($sformatf("random%0d", r), 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
